rf_wb_queue: RTL and testbench
==============================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..8).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  producer presents a writeback result.
REQ-005 in_ready  output  1  queue can accept a result this cycle.
REQ-006 in_addr  input  3  destination register index.
REQ-007 in_data  input  16  result data.
REQ-008 in_only_high  input  1  update bits [15:8] only.
REQ-009 hold  input  1  register-file write port unavailable; inhibits draining.
REQ-010 wr_en  output  1  register-file write enable.
REQ-011 wr_addr  output  3  register-file write address.
REQ-012 wr_data  output  16  register-file write data.
REQ-013 wr_only_high  output  1  register-file high-byte-only write.
REQ-014 rd_addr_a, rd_addr_b  input  3 each  read-port addresses to check against pending writes.
REQ-015 fwd_hit_a, fwd_hit_b  output  1 each  a queued write targets that address.
REQ-016 fwd_partial_a, fwd_partial_b  output  1 each  youngest matching write is high-byte-only.
REQ-017 fwd_data_a, fwd_data_b  output  16 each  forwarded data.
REQ-018 count  output  $clog2(DEPTH)+1  occupied entries; empty  output  1  count==0.

Function
REQ-019 Queue SHALL be in-order FIFO: entry = {addr, data, only_high}; head/tail pointers wrap modulo DEPTH.
REQ-020 in_ready SHALL equal (count < DEPTH), registered-state only, no combinational path from in_valid or hold.
REQ-021 Push SHALL occur on an edge where in_valid && in_ready; tail advances, count +1.
REQ-022 wr_en SHALL equal (!empty && !hold), combinational; wr_addr/wr_data/wr_only_high SHALL show head entry whenever !empty, else 0.
REQ-023 Pop SHALL occur on every edge where wr_en=1; head advances, count -1; one write per cycle max.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push into empty queue SHALL reach wr_* no earlier than next cycle (latency 1 cycle from accept to wr_en).
REQ-025 Full queue (count==DEPTH) SHALL deassert in_ready even if a pop occurs that cycle.
REQ-026 hold=1 SHALL freeze head and contents; pushes still accepted while not full.
REQ-027 Forwarding SHALL search only queued entries (not the in_* bus), youngest to oldest, per port independently.
REQ-028 No match: fwd_hit=0, fwd_partial=0, fwd_data=0.
REQ-029 Youngest match full-width: fwd_hit=1, fwd_partial=0, fwd_data=entry data.
REQ-030 Youngest match high-only: fwd_hit=1, fwd_partial=1, fwd_data={entry data[15:8], 8'h00}; consumer SHALL stall on partial.
REQ-031 Entry being popped this cycle SHALL still participate in forwarding this cycle.
REQ-032 Register index 0 SHALL be treated like any other index (no hard-wired zero).

Reset
REQ-033 rst=0 SHALL immediately clear pointers, count=0, empty=1, in_ready=1, wr_en=0, wr_*=0, all fwd_*=0, independent of clk.
REQ-034 Reset mid-operation SHALL discard all queued entries; no write SHALL issue for them after release.
REQ-035 First push SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-036 Push {r3,16'hABCD,full}, hold=0 -> next cycle wr_en=1, wr_addr=3, wr_data=ABCD, following cycle empty=1.
REQ-037 hold=1, push 4 entries r1..r4 -> count=4, in_ready=0, wr_en=0; fifth in_valid not accepted; release hold -> writes r1,r2,r3,r4 in order on 4 consecutive cycles.
REQ-038 Queue r5=1111 full then r5=2200 high-only, rd_addr_a=5 -> fwd_hit_a=1, fwd_partial_a=1, fwd_data_a=2200; rd_addr_b=6 -> fwd_hit_b=0, fwd_data_b=0.
REQ-039 Count=2, push and pop same edge -> count stays 2, order preserved across pointer wrap after 6 more push/pop pairs.
REQ-040 Count=3, assert rst=0 between edges -> wr_en=0, count=0 immediately; after release no stale writes observed over 5 cycles.

Source files
------------

// File: rtl/rf_wb_queue_if.sv
// Bus bundle for the register-file writeback queue: producer handshake,
// register-file write port, forwarding lookups and occupancy status.
// The master side is the producer/consumer environment, the slave side is
// the queue itself.
interface rf_wb_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // producer side
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_addr;
    logic [15:0]      in_data;
    logic             in_only_high;

    // register-file write port
    logic             hold;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [15:0]      wr_data;
    logic             wr_only_high;

    // forwarding lookups
    logic [2:0]       rd_addr_a;
    logic [2:0]       rd_addr_b;
    logic             fwd_hit_a;
    logic             fwd_hit_b;
    logic             fwd_partial_a;
    logic             fwd_partial_b;
    logic [15:0]      fwd_data_a;
    logic [15:0]      fwd_data_b;

    // occupancy
    logic [CNT_W-1:0] count;
    logic             empty;

    modport master (
        output in_valid, in_addr, in_data, in_only_high, hold, rd_addr_a, rd_addr_b,
        input  in_ready, wr_en, wr_addr, wr_data, wr_only_high,
        input  fwd_hit_a, fwd_hit_b, fwd_partial_a, fwd_partial_b, fwd_data_a, fwd_data_b,
        input  count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_only_high, hold, rd_addr_a, rd_addr_b,
        output in_ready, wr_en, wr_addr, wr_data, wr_only_high,
        output fwd_hit_a, fwd_hit_b, fwd_partial_a, fwd_partial_b, fwd_data_a, fwd_data_b,
        output count, empty
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Register-file writeback queue.
// In-order FIFO of {addr, data, only_high} results waiting for the single
// register-file write port. The head entry is written whenever the port is
// free (hold low). Two read ports can look up pending writes; the youngest
// queued entry for the address wins, and a high-byte-only entry is reported
// as partial so the consumer knows the low byte is not available here.
// Occupancy and in_ready come from registered state only, so there is no
// combinational path from in_valid/hold to in_ready.
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_queue_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Forwarded value of one entry: a high-only entry exposes only its upper byte.
    function automatic logic [15:0] fwd_value(input logic [15:0] data, input logic only_high);
        logic [15:0] v;
        if (only_high) begin
            v = {data[15:8], 8'h00};
        end else begin
            v = data;
        end
        return v;
    endfunction

    // storage
    logic [2:0]       r_addr_mem [DEPTH];
    logic [15:0]      r_data_mem [DEPTH];
    logic [DEPTH-1:0] r_high_mem;

    // pointers and occupancy
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // control
    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // head view
    logic [2:0]       w_wr_addr;
    logic [15:0]      w_wr_data;
    logic             w_wr_only_high;

    // forwarding
    logic [PTR_W-1:0] w_slot [DEPTH];
    logic [DEPTH-1:0] w_live;
    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_part_a;
    logic             w_part_b;
    logic [15:0]      w_fdat_a;
    logic [15:0]      w_fdat_b;

    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_ready = (r_count < DEPTH_C);
    assign w_push  = bus.in_valid && w_ready;
    assign w_pop   = !w_empty && !bus.hold;

    // Slot k holds the k-th oldest entry; it is live only if k < count.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign w_slot[k] = r_head + PTR_W'(k);
        assign w_live[k] = (CNT_W'(k) < r_count);
    end

    // Occupancy next value: a simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy registers; reset discards everything queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_head <= r_head + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage: write the accepted result at the tail slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= 3'd0;
                r_data_mem[i] <= 16'h0000;
            end
            r_high_mem <= {DEPTH{1'b0}};
        end else begin
            if (w_push) begin
                r_addr_mem[r_tail] <= bus.in_addr;
                r_data_mem[r_tail] <= bus.in_data;
                r_high_mem[r_tail] <= bus.in_only_high;
            end
        end
    end

    // Head entry drives the write port; zeros when nothing is queued.
    always_comb begin
        w_wr_addr      = 3'd0;
        w_wr_data      = 16'h0000;
        w_wr_only_high = 1'b0;
        if (!w_empty) begin
            w_wr_addr      = r_addr_mem[r_head];
            w_wr_data      = r_data_mem[r_head];
            w_wr_only_high = r_high_mem[r_head];
        end else begin
            w_wr_addr      = 3'd0;
            w_wr_data      = 16'h0000;
            w_wr_only_high = 1'b0;
        end
    end

    // Forwarding search oldest to youngest so the youngest match is left standing.
    // The head entry is searched even on the cycle it is being written out.
    always_comb begin
        w_hit_a  = 1'b0;
        w_part_a = 1'b0;
        w_fdat_a = 16'h0000;
        w_hit_b  = 1'b0;
        w_part_b = 1'b0;
        w_fdat_b = 16'h0000;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k] && (r_addr_mem[w_slot[k]] == bus.rd_addr_a)) begin
                w_hit_a  = 1'b1;
                w_part_a = r_high_mem[w_slot[k]];
                w_fdat_a = fwd_value(r_data_mem[w_slot[k]], r_high_mem[w_slot[k]]);
            end else begin
                w_hit_a  = w_hit_a;
                w_part_a = w_part_a;
                w_fdat_a = w_fdat_a;
            end
            if (w_live[k] && (r_addr_mem[w_slot[k]] == bus.rd_addr_b)) begin
                w_hit_b  = 1'b1;
                w_part_b = r_high_mem[w_slot[k]];
                w_fdat_b = fwd_value(r_data_mem[w_slot[k]], r_high_mem[w_slot[k]]);
            end else begin
                w_hit_b  = w_hit_b;
                w_part_b = w_part_b;
                w_fdat_b = w_fdat_b;
            end
        end
    end

    assign bus.in_ready      = w_ready;
    assign bus.wr_en         = w_pop;
    assign bus.wr_addr       = w_wr_addr;
    assign bus.wr_data       = w_wr_data;
    assign bus.wr_only_high  = w_wr_only_high;
    assign bus.fwd_hit_a     = w_hit_a;
    assign bus.fwd_partial_a = w_part_a;
    assign bus.fwd_data_a    = w_fdat_a;
    assign bus.fwd_hit_b     = w_hit_b;
    assign bus.fwd_partial_b = w_part_b;
    assign bus.fwd_data_b    = w_fdat_b;
    assign bus.count         = r_count;
    assign bus.empty         = w_empty;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue (DEPTH = 4).
module tb_rf_wb_queue;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    rf_wb_queue_if #(.DEPTH(4)) bus ();

    rf_wb_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // free-running clock, period 10
    always #5 clk = ~clk;

    // single comparison point: count it, report a mismatch
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [15:0] d, input logic hi);
        bus.in_valid     = v;
        bus.in_addr      = a;
        bus.in_data      = d;
        bus.in_only_high = hi;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        bus.hold      = 1'b0;
        bus.rd_addr_a = 3'd0;
        bus.rd_addr_b = 3'd0;

        // reset state
        #3;
        check("rst_count",   32'(bus.count),     32'd0);
        check("rst_empty",   32'(bus.empty),     32'd1);
        check("rst_ready",   32'(bus.in_ready),  32'd1);
        check("rst_wr_en",   32'(bus.wr_en),     32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr),   32'd0);
        check("rst_wr_data", 32'(bus.wr_data),   32'd0);
        check("rst_fwd_a",   32'(bus.fwd_hit_a), 32'd0);
        check("rst_fwd_b",   32'(bus.fwd_hit_b), 32'd0);

        // single push of r3=ABCD, accepted on the first edge after release
        drive(1'b1, 3'd3, 16'hABCD, 1'b0);
        bus.rd_addr_a = 3'd3;
        #5;
        rst = 1'b1;
        #1;
        check("inbus_not_fwd", 32'(bus.fwd_hit_a), 32'd0);
        check("pre_push_wr_en", 32'(bus.wr_en),    32'd0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        #1;
        check("p1_wr_en",    32'(bus.wr_en),        32'd1);
        check("p1_wr_addr",  32'(bus.wr_addr),      32'd3);
        check("p1_wr_data",  32'(bus.wr_data),      32'hABCD);
        check("p1_wr_hi",    32'(bus.wr_only_high), 32'd0);
        check("p1_count",    32'(bus.count),        32'd1);
        check("p1_fwd_hit",  32'(bus.fwd_hit_a),    32'd1);
        check("p1_fwd_data", 32'(bus.fwd_data_a),   32'hABCD);
        step();
        check("p1_empty",    32'(bus.empty),        32'd1);
        check("p1_wr_en_0",  32'(bus.wr_en),        32'd0);
        check("p1_wr_data0", 32'(bus.wr_data),      32'd0);

        // hold: fill r1..r4, fifth result refused, then drain in order
        bus.hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 3'(k), 16'h1000 + 16'(k), 1'b0);
            step();
        end
        drive(1'b1, 3'd7, 16'h7777, 1'b0);
        #1;
        check("full_count", 32'(bus.count),    32'd4);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        check("full_wr_en", 32'(bus.wr_en),    32'd0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        check("fifth_refused", 32'(bus.count), 32'd4);
        bus.hold = 1'b0;
        #1;
        check("full_pop_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check("drain_wr_en",   32'(bus.wr_en),   32'd1);
            check("drain_wr_addr", 32'(bus.wr_addr), 32'(k));
            check("drain_wr_data", 32'(bus.wr_data), 32'h1000 + 32'(k));
            step();
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // forwarding: youngest r5 is high-only; r0 behaves like any index
        bus.hold = 1'b1;
        drive(1'b1, 3'd5, 16'h1111, 1'b0);
        step();
        drive(1'b1, 3'd5, 16'h22EE, 1'b1);
        step();
        drive(1'b1, 3'd0, 16'h00EE, 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        bus.rd_addr_a = 3'd5;
        bus.rd_addr_b = 3'd6;
        #1;
        check("fwd_a_hit",  32'(bus.fwd_hit_a),     32'd1);
        check("fwd_a_part", 32'(bus.fwd_partial_a), 32'd1);
        check("fwd_a_data", 32'(bus.fwd_data_a),    32'h2200);
        check("fwd_b_hit",  32'(bus.fwd_hit_b),     32'd0);
        check("fwd_b_part", 32'(bus.fwd_partial_b), 32'd0);
        check("fwd_b_data", 32'(bus.fwd_data_b),    32'd0);
        bus.rd_addr_b = 3'd0;
        #1;
        check("fwd_r0_hit",  32'(bus.fwd_hit_b),     32'd1);
        check("fwd_r0_part", 32'(bus.fwd_partial_b), 32'd0);
        check("fwd_r0_data", 32'(bus.fwd_data_b),    32'h00EE);
        bus.hold = 1'b0;
        step();
        step();
        step();
        check("fwd_drained", 32'(bus.empty), 32'd1);

        // steady push+pop at count 2, wrapping the pointers twice
        bus.hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'(k), 16'h3900 + 16'(k), 1'b0);
            step();
        end
        bus.hold = 1'b0;
        for (int j = 0; j < 7; j++) begin
            drive(1'b1, 3'((j + 2) % 8), 16'h3902 + 16'(j), 1'b0);
            #1;
            check("pp_wr_en",   32'(bus.wr_en),   32'd1);
            check("pp_wr_data", 32'(bus.wr_data), 32'h3900 + 32'(j));
            check("pp_count",   32'(bus.count),   32'd2);
            step();
        end
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        check("pp_count_end", 32'(bus.count), 32'd2);
        for (int j = 7; j < 9; j++) begin
            check("pp_tail_data", 32'(bus.wr_data), 32'h3900 + 32'(j));
            step();
        end
        check("pp_empty", 32'(bus.empty), 32'd1);

        // reset between edges with three entries queued
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd4 + 3'(k), 16'h4400 + 16'(k), 1'b0);
            step();
        end
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
        bus.hold      = 1'b0;
        bus.rd_addr_a = 3'd4;
        #1;
        check("prerst_count", 32'(bus.count), 32'd3);
        check("prerst_wr_en", 32'(bus.wr_en), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_wr_en",   32'(bus.wr_en),     32'd0);
        check("midrst_count",   32'(bus.count),     32'd0);
        check("midrst_empty",   32'(bus.empty),     32'd1);
        check("midrst_ready",   32'(bus.in_ready),  32'd1);
        check("midrst_wr_addr", 32'(bus.wr_addr),   32'd0);
        check("midrst_fwd",     32'(bus.fwd_hit_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            check("postrst_no_wr", 32'(bus.wr_en), 32'd0);
            check("postrst_empty", 32'(bus.empty), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
